// File: rtl/seg7_scan_display_pkg.sv
// Shared constants for the seven-segment scan display: active-low segment
// codes, blank/off patterns and the default register-select wrap point.
package seg7_scan_display_pkg;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    localparam int SEL_MAX_DEFAULT = 16;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] code;
        case (nibble)
            4'h0: code = SEG_0;
            4'h1: code = SEG_1;
            4'h2: code = SEG_2;
            4'h3: code = SEG_3;
            4'h4: code = SEG_4;
            4'h5: code = SEG_5;
            4'h6: code = SEG_6;
            4'h7: code = SEG_7;
            4'h8: code = SEG_8;
            4'h9: code = SEG_9;
            4'hA: code = SEG_A;
            4'hB: code = SEG_B;
            4'hC: code = SEG_C;
            4'hD: code = SEG_D;
            4'hE: code = SEG_E;
            default: code = SEG_F;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and a
// registered single-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock,
    input  logic resetn,
    input  logic raw,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (resetn) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            press <= 1'b0;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Accept the new level; only a rising acceptance is a press.
                stable <= s2;
                cnt    <= '0;
                press  <= s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed 8-digit hex display of the CPU register-view word, plus the
// button-driven register select that feeds back into the CPU.
module seg7_scan_display
    import seg7_scan_display_pkg::*;
#(
    parameter int SCAN_DIV        = 100000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SEL_MAX         = SEL_MAX_DEFAULT
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] value,
    input  logic        btn_next,
    input  logic        btn_prev,
    output logic [4:0]  sel_num,
    output logic [7:0]  an,
    output logic [6:0]  seg
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [4:0]    SEL_TOP  = 5'(SEL_MAX);

    logic [PW-1:0] pre;
    logic          tick;
    logic [2:0]    idx;
    logic [2:0]    idx_next;
    logic [31:0]   shadow;
    logic [3:0]    nibble;
    logic          next_pulse;
    logic          prev_pulse;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clock  (clock),
        .resetn (resetn),
        .raw    (btn_next),
        .press  (next_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
        .clock  (clock),
        .resetn (resetn),
        .raw    (btn_prev),
        .press  (prev_pulse)
    );

    assign tick     = (pre == PRE_LAST);
    assign idx_next = idx + 3'd1;

    // Digit 0 reads the live word on the same edge it is latched, so the
    // whole frame comes from one snapshot.
    always_comb begin
        nibble = shadow[{idx_next, 2'b00} +: 4];
        if (idx_next == 3'd0) begin
            nibble = value[3:0];
        end
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            pre    <= '0;
            idx    <= 3'd7;
            an     <= AN_OFF;
            seg    <= SEG_BLANK;
            shadow <= '0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) begin
                idx <= idx_next;
                an  <= ~(8'd1 << idx_next);
                seg <= hex_to_seg(nibble);
                if (idx_next == 3'd0) begin
                    shadow <= value;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            sel_num <= 5'd0;
        end else begin
            case ({next_pulse, prev_pulse})
                2'b10:   sel_num <= (sel_num == SEL_TOP) ? 5'd0 : sel_num + 5'd1;
                2'b01:   sel_num <= (sel_num == 5'd0) ? SEL_TOP : sel_num - 5'd1;
                default: sel_num <= sel_num;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with a short scan period and short
// debounce window so every behaviour is reachable in a few hundred cycles.
module tb_seg7_scan_display;

    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic [31:0] value = 32'h0;
    logic        btn_next = 1'b0;
    logic        btn_prev = 1'b0;
    logic [4:0]  sel_num;
    logic [7:0]  an;
    logic [6:0]  seg;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_scan_display #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (3),
        .SEL_MAX         (16)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .value    (value),
        .btn_next (btn_next),
        .btn_prev (btn_prev),
        .sel_num  (sel_num),
        .an       (an),
        .seg      (seg)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic nxt, input logic prv);
        btn_next = nxt;
        btn_prev = prv;
        step(8);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        step(8);
    endtask

    logic [7:0] an_exp  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [6:0] seg_exp [8] = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};

    initial begin
        // Reset state
        step(2);
        check("reset_an", 32'(an), 32'hFF);
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_sel", 32'(sel_num), 32'd0);
        value  = 32'h12345678;
        resetn = 1'b0;

        // Full frame of 12345678, then wrap back to digit 0
        step(3);
        check("pre_first_an", 32'(an), 32'hFF);
        step(1);
        check("scan_an_d0", 32'(an), 32'(an_exp[0]));
        check("scan_seg_d0", 32'(seg), 32'(seg_exp[0]));
        for (int i = 1; i < 8; i++) begin
            step(4);
            check($sformatf("scan_an_d%0d", i), 32'(an), 32'(an_exp[i]));
            check($sformatf("scan_seg_d%0d", i), 32'(seg), 32'(seg_exp[i]));
        end
        step(4);
        check("scan_wrap_an", 32'(an), 32'hFE);
        check("scan_wrap_seg", 32'(seg), 32'h00);

        // Frame latch: change value while digit 3 is lit
        step(12);
        check("latch_d3_an", 32'(an), 32'hF7);
        value = 32'hFFFFFFFF;
        for (int i = 4; i < 8; i++) begin
            step(4);
            check($sformatf("latch_an_d%0d", i), 32'(an), 32'(an_exp[i]));
            check($sformatf("latch_seg_d%0d", i), 32'(seg), 32'(seg_exp[i]));
        end
        step(4);
        check("latch_new_d0_an", 32'(an), 32'hFE);
        check("latch_new_d0_seg", 32'(seg), 32'h0E);
        step(4);
        check("latch_new_d1_seg", 32'(seg), 32'h0E);

        // Clean press: step exactly 6 edges after the raw rise, once only
        btn_next = 1'b1;
        step(5);
        check("press_early", 32'(sel_num), 32'd0);
        step(1);
        check("press_step", 32'(sel_num), 32'd1);
        step(4);
        check("press_held", 32'(sel_num), 32'd1);
        btn_next = 1'b0;
        step(8);
        check("release", 32'(sel_num), 32'd1);

        // Two-cycle glitch is rejected
        btn_next = 1'b1;
        step(2);
        btn_next = 1'b0;
        step(10);
        check("glitch", 32'(sel_num), 32'd1);

        // Wrap upward 16 -> 0, then downward 0 -> 16
        for (int i = 0; i < 15; i++) press(1'b1, 1'b0);
        check("up_to_max", 32'(sel_num), 32'd16);
        press(1'b1, 1'b0);
        check("wrap_up", 32'(sel_num), 32'd0);
        press(1'b0, 1'b1);
        check("wrap_down", 32'(sel_num), 32'd16);

        // Simultaneous presses cancel
        press(1'b1, 1'b1);
        check("both", 32'(sel_num), 32'd16);

        // Reach 7, then reset in the middle of digit 5
        for (int i = 0; i < 8; i++) press(1'b1, 1'b0);
        check("sel_seven", 32'(sel_num), 32'd7);
        begin
            bit found = 1'b0;
            for (int i = 0; i < 64 && !found; i++) begin
                step(1);
                if (an == 8'hDF) found = 1'b1;
            end
            n_checks++;
            assert (found)
            else begin
                n_fail++;
                $error("FAIL wait_digit5: observed timeout expected an=df");
            end
        end
        step(1);
        resetn = 1'b1;
        step(1);
        check("midreset_an", 32'(an), 32'hFF);
        check("midreset_seg", 32'(seg), 32'h7F);
        check("midreset_sel", 32'(sel_num), 32'd0);
        resetn = 1'b0;
        step(3);
        check("restart_pre_an", 32'(an), 32'hFF);
        step(1);
        check("restart_an", 32'(an), 32'hFE);
        check("restart_seg", 32'(seg), 32'h0E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
Board-side display stage directly downstream of the single-cycle CPU. It consumes the CPU's 32-bit register-view word (out_num) and scans it as 8 hex digits onto a multiplexed, active-low seven-segment display. It also produces the CPU's 5-bit register-select input (sel_num) from two debounced push buttons, closing the CPU-to-display loop.

Parameters:
SCAN_DIV, 100000, clock cycles each digit stays lit (>=2)
DEBOUNCE_CYCLES, 1000000, consecutive stable samples needed to accept a button change (>=2)
SEL_MAX, 16, highest sel_num value; wrap point

Ports:
clock  in  1  system clock, all state on rising edge
resetn  in  1  synchronous, active-high reset (1 = reset); named as the CPU's reset is
value  in  32  word to display, driven by CPU out_num
btn_next  in  1  raw asynchronous button, step select up
btn_prev  in  1  raw asynchronous button, step select down
sel_num  out  5  register select to CPU
an  out  8  digit anodes, active low, one-hot-low when lit
seg  out  7  cathodes {g,f,e,d,c,b,a}, active low

Behaviour:
- Reset (resetn=1 at an edge): an=8'hFF, seg=7'h7F, sel_num=0, digit index=7, prescaler=0, shadow=0, sync/debounce state=0, debounce counters=0. Reset dominates all other events, including mid-scan and mid-debounce.
- Prescaler counts 0..SCAN_DIV-1. tick=1 when the count is SCAN_DIV-1; the count then wraps to 0.
- On tick: idx<=idx+1 (mod 8, 7->0). an<=~(1<<idx_next). seg<=decode(nibble idx_next). an and seg are registered and change on the same edge.
- Frame latch: when idx_next==0, shadow<=value, and digit 0 decodes value[3:0] directly. Digits 1..7 decode shadow[4i+3:4i]. Changes to value mid-frame never tear a frame.
- First lit digit (digit 0) appears SCAN_DIV edges after reset deasserts.
- Decode, hex active low: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Debounce, per button:
  - Two-flop synchroniser: raw -> s1 -> s2.
  - If s2==stable, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 with s2 still differing, stable<=s2 and the counter clears.
  - Any glitch back resets the count.
  - A press pulse is a registered 1-cycle pulse on a stable 0->1 transition. Release generates nothing.
- sel_num update, on the edge after the pulse:
  - next only: sel_num==SEL_MAX ? 0 : sel_num+1.
  - prev only: sel_num==0 ? SEL_MAX : sel_num-1.
  - Both pulses in the same cycle: no change.
- Latency: a clean raw rise changes sel_num exactly DEBOUNCE_CYCLES+3 edges later.
- A held button produces one step only (no auto-repeat).
- sel_num never exceeds SEL_MAX.

Decomposition:
- Shared package: the SEG_* constants for the 16 hex codes, the blank code 7'h7F, the anode-off constant 8'hFF, and SEL_MAX's default.
- One sub-module, btn_debounce (synchroniser + counter + press pulse, parameter DEBOUNCE_CYCLES), instantiated twice.
- Scan counter, frame latch, decoder and sel_num stepping stay in the top.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_CYCLES=3.
- Reset, then value=32'h12345678. Edge 4: an=FE, seg=00 (8). Edge 8: an=FD, seg=78 (7). Continue through edge 32: an=7F, seg=79 (1). Edge 36: an=FE again.
- Frame latch: switch value to FFFFFFFF while digit 3 is lit. Digits 4..7 still show 19, 30, 24, 79. The next digit 0 and all following digits show 0E.
- Clean btn_next press held 10 cycles: sel_num 0->1 exactly 6 edges after the raw rise, with no further step while held. A 2-cycle glitch produces no change.
- Wrap: press next 17 times from 0, giving ...16->0. Press prev once from 0, giving 16.
- Both buttons pressed on the same edge: sel_num unchanged.
- resetn asserted during digit 5 with sel_num=7: on the next edge an=FF, seg=7F, sel_num=0. Scan restarts with digit 0 4 edges after release.
